// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the SPARC V8 multiply/divide sequencer.
//   - op3 codes of the supported operations
//   - FSM state encoding
//   - saturation / error result constants
package muldiv_pkg;

    localparam logic [5:0] OP3_UMUL = 6'h0A;
    localparam logic [5:0] OP3_SMUL = 6'h0B;
    localparam logic [5:0] OP3_UDIV = 6'h0E;
    localparam logic [5:0] OP3_SDIV = 6'h0F;

    localparam logic [31:0] SAT_UDIV    = 32'hFFFF_FFFF;
    localparam logic [31:0] SAT_SPOS    = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_SNEG    = 32'h8000_0000;
    localparam logic [31:0] RES_DIVZERO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_MUL  = 3'd2,
        ST_DIV  = 3'd3,
        ST_FIX  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Two's-complement magnitude of a 32-bit value when neg is set.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: operand capture, sign/magnitude preparation, iterative
// shift-add multiplier, restoring divider and final sign/saturation fix-up.
// Build option: MDU_EARLY_OUT_EN - the multiply loop may exit as soon as the
// remaining multiplier is zero (the result is unchanged, only latency drops).
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   capture_i                  latch op3_i / a_i / b_i / y_i
//   load_i, step_i, fix_i      prepare, iterate, finalise strobes from the FSM
//   supported_o, is_mul_o      decode of the latched op3
//   prep_exit_o                divide by zero or divide overflow detected
//   cnt_last_o                 the current iteration is the 32nd
//   mul_pre_exit_o             skip the multiply iteration, go to fix-up
//   mul_post_exit_o            this multiply iteration is the final one
//   res_o, y_o, y_we_o, divzero_o  registered results
module muldiv_datapath
    import muldiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        capture_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        fix_i,
    input  logic [5:0]  op3_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] y_i,
    output logic        supported_o,
    output logic        is_mul_o,
    output logic        prep_exit_o,
    output logic        cnt_last_o,
    output logic        mul_pre_exit_o,
    output logic        mul_post_exit_o,
    output logic [31:0] res_o,
    output logic [31:0] y_o,
    output logic        y_we_o,
    output logic        divzero_o
);

    logic [5:0]  op_q;
    logic [31:0] a_q, b_q, yin_q;
    logic [63:0] acc_q, mcand_q;
    logic [31:0] mplier_q;
    logic [5:0]  cnt_q;
    logic        neg_q, ovf_q, dz_q;
    logic [31:0] res_q, yout_q;
    logic        ywe_q, divz_q;

    logic        is_umul_s, is_smul_s, is_udiv_s, is_sdiv_s, is_mul_s, is_div_s;
    logic        a_neg_s, b_neg_s, dvd_neg_s, sign_s, divzero_s, ovf_prep_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic [63:0] dvd_mag_s, acc_mul_s, acc_div_s, prod_s;
    logic [64:0] shifted_s;
    logic [32:0] trial_s;
    logic [31:0] q_s, res_fix_s, yout_fix_s;
    logic        ywe_fix_s, dz_fix_s;

    assign is_umul_s = (op_q == OP3_UMUL);
    assign is_smul_s = (op_q == OP3_SMUL);
    assign is_udiv_s = (op_q == OP3_UDIV);
    assign is_sdiv_s = (op_q == OP3_SDIV);
    assign is_mul_s  = is_umul_s | is_smul_s;
    assign is_div_s  = is_udiv_s | is_sdiv_s;

    // Only one of a_neg / dvd_neg can be set for a given op, so the result
    // sign is a plain XOR of the operand signs.
    assign a_neg_s   = is_smul_s & a_q[31];
    assign b_neg_s   = (is_smul_s | is_sdiv_s) & b_q[31];
    assign dvd_neg_s = is_sdiv_s & yin_q[31];
    assign sign_s    = (a_neg_s | dvd_neg_s) ^ b_neg_s;
    assign a_mag_s   = mag32(a_q, a_neg_s);
    assign b_mag_s   = mag32(b_q, b_neg_s);
    assign dvd_mag_s = dvd_neg_s ? (64'd0 - {yin_q, a_q}) : {yin_q, a_q};

    // A quotient that cannot fit in 32 bits shows up as high word >= divisor.
    assign divzero_s  = is_div_s & (b_q == 32'd0);
    assign ovf_prep_s = is_div_s & ~divzero_s & (dvd_mag_s[63:32] >= b_mag_s);

    assign acc_mul_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Restoring step: the partial remainder stays below the divisor, so bit 32
    // of the trial difference is set exactly when the subtraction would borrow.
    assign shifted_s = {acc_q, 1'b0};
    assign trial_s   = shifted_s[64:32] - {1'b0, mplier_q};
    assign acc_div_s = trial_s[32] ? shifted_s[63:0] : {trial_s[31:0], shifted_s[31:1], 1'b1};

    assign prod_s = neg_q ? (64'd0 - acc_q) : acc_q;
    assign q_s    = acc_q[31:0];

    // Final result selection: sign fix-up, saturation and error codes.
    always_comb begin
        res_fix_s  = 32'd0;
        yout_fix_s = 32'd0;
        ywe_fix_s  = 1'b0;
        dz_fix_s   = 1'b0;
        if (is_mul_s) begin
            res_fix_s  = prod_s[31:0];
            yout_fix_s = prod_s[63:32];
            ywe_fix_s  = 1'b1;
        end else if (is_div_s) begin
            if (dz_q) begin
                res_fix_s = RES_DIVZERO;
                dz_fix_s  = 1'b1;
            end else if (is_sdiv_s) begin
                if (neg_q) begin
                    if (ovf_q || (q_s > SAT_SNEG)) begin
                        res_fix_s = SAT_SNEG;
                    end else begin
                        res_fix_s = 32'd0 - q_s;
                    end
                end else begin
                    if (ovf_q || (q_s > SAT_SPOS)) begin
                        res_fix_s = SAT_SPOS;
                    end else begin
                        res_fix_s = q_s;
                    end
                end
            end else begin
                if (ovf_q) begin
                    res_fix_s = SAT_UDIV;
                end else begin
                    res_fix_s = q_s;
                end
            end
        end else begin
            res_fix_s = 32'd0;
        end
    end

    // Request capture registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q  <= 6'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            yin_q <= 32'd0;
        end else if (capture_i) begin
            op_q  <= op3_i;
            a_q   <= a_i;
            b_q   <= b_i;
            yin_q <= y_i;
        end
    end

    // Iteration registers: loaded in PREP, advanced once per MUL/DIV cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            cnt_q    <= 6'd0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else if (load_i) begin
            cnt_q    <= 6'd0;
            neg_q    <= sign_s;
            ovf_q    <= ovf_prep_s;
            dz_q     <= divzero_s;
            mplier_q <= b_mag_s;
            if (is_div_s) begin
                acc_q   <= dvd_mag_s;
                mcand_q <= 64'd0;
            end else begin
                acc_q   <= 64'd0;
                mcand_q <= {32'd0, a_mag_s};
            end
        end else if (step_i) begin
            cnt_q <= cnt_q + 6'd1;
            if (is_div_s) begin
                acc_q <= acc_div_s;
            end else begin
                acc_q    <= acc_mul_s;
                mcand_q  <= {mcand_q[62:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[31:1]};
            end
        end
    end

    // Output registers, held stable until the next fix-up.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_q  <= 32'd0;
            yout_q <= 32'd0;
            ywe_q  <= 1'b0;
            divz_q <= 1'b0;
        end else if (fix_i) begin
            res_q  <= res_fix_s;
            yout_q <= yout_fix_s;
            ywe_q  <= ywe_fix_s;
            divz_q <= dz_fix_s;
        end
    end

    assign supported_o = is_mul_s | is_div_s;
    assign is_mul_o    = is_mul_s;
    assign prep_exit_o = divzero_s | ovf_prep_s;
    assign cnt_last_o  = (cnt_q == 6'd31);
`ifdef MDU_EARLY_OUT_EN
    assign mul_pre_exit_o  = (mplier_q == 32'd0);
    assign mul_post_exit_o = 1'b0;
`else
    assign mul_pre_exit_o  = 1'b0;
    assign mul_post_exit_o = cnt_last_o;
`endif
    assign res_o     = res_q;
    assign y_o       = yout_q;
    assign y_we_o    = ywe_q;
    assign divzero_o = divz_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle UMUL/SMUL/UDIV/SDIV unit beside the execute ALU.
// Holds the control FSM and the request/response handshake; arithmetic lives in
// muldiv_datapath.
// Build option: MDU_EARLY_OUT_EN - multiply finishes once the remaining
// multiplier is zero (handled inside muldiv_datapath).
// Ports:
//   MDU_clk_in, MDU_reset_in            clock, asynchronous active-high reset
//   MDU_req_valid_in / MDU_req_ready_out request handshake
//   MDU_op3_in, MDU_valA_in, MDU_valB_in, MDU_Y_in  operation and operands
//   MDU_flush_in                        abort any operation in progress
//   MDU_resp_valid_out / MDU_resp_ready_in  response handshake
//   MDU_res_out, MDU_Y_out, MDU_Y_we_out, MDU_divzero_out  results
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MDU_XLEN = 32
) (
    input  logic                MDU_clk_in,
    input  logic                MDU_reset_in,
    input  logic                MDU_req_valid_in,
    output logic                MDU_req_ready_out,
    input  logic [5:0]          MDU_op3_in,
    input  logic [MDU_XLEN-1:0] MDU_valA_in,
    input  logic [MDU_XLEN-1:0] MDU_valB_in,
    input  logic [MDU_XLEN-1:0] MDU_Y_in,
    input  logic                MDU_flush_in,
    output logic                MDU_resp_valid_out,
    input  logic                MDU_resp_ready_in,
    output logic [MDU_XLEN-1:0] MDU_res_out,
    output logic [MDU_XLEN-1:0] MDU_Y_out,
    output logic                MDU_Y_we_out,
    output logic                MDU_divzero_out
);

    state_e state_q, state_d, fsm_next_s;
    logic   resp_valid_q;
    logic   req_ready_s, abort_s;
    logic   capture_s, load_n_s, step_n_s, fix_n_s;
    logic   supported_s, is_mul_s, prep_exit_s, cnt_last_s;
    logic   mul_pre_exit_s, mul_post_exit_s;

    // Ready is also held low while reset is asserted.
    assign req_ready_s = (state_q == ST_IDLE) & ~MDU_flush_in & ~MDU_reset_in;
    assign abort_s     = MDU_flush_in & (state_q != ST_IDLE);

    // Next-state and datapath strobe decode.
    always_comb begin
        fsm_next_s = state_q;
        capture_s  = 1'b0;
        load_n_s   = 1'b0;
        step_n_s   = 1'b0;
        fix_n_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MDU_req_valid_in && req_ready_s) begin
                    capture_s  = 1'b1;
                    fsm_next_s = ST_PREP;
                end else begin
                    fsm_next_s = ST_IDLE;
                end
            end
            ST_PREP: begin
                load_n_s = 1'b1;
                if (!supported_s) begin
                    fsm_next_s = ST_FIX;
                end else if (is_mul_s) begin
                    fsm_next_s = ST_MUL;
                end else if (prep_exit_s) begin
                    fsm_next_s = ST_FIX;
                end else begin
                    fsm_next_s = ST_DIV;
                end
            end
            ST_MUL: begin
                if (mul_pre_exit_s) begin
                    fsm_next_s = ST_FIX;
                end else begin
                    step_n_s   = 1'b1;
                    fsm_next_s = mul_post_exit_s ? ST_FIX : ST_MUL;
                end
            end
            ST_DIV: begin
                step_n_s   = 1'b1;
                fsm_next_s = cnt_last_s ? ST_FIX : ST_DIV;
            end
            ST_FIX: begin
                fix_n_s    = 1'b1;
                fsm_next_s = ST_DONE;
            end
            ST_DONE: begin
                if (MDU_resp_ready_in) begin
                    fsm_next_s = ST_IDLE;
                end else begin
                    fsm_next_s = ST_DONE;
                end
            end
            default: begin
                fsm_next_s = ST_IDLE;
            end
        endcase
    end

    // A flush overrides everything outside IDLE and suppresses datapath updates.
    assign state_d = abort_s ? ST_IDLE : fsm_next_s;

    // State and response-valid registers.
    always_ff @(posedge MDU_clk_in or posedge MDU_reset_in) begin
        if (MDU_reset_in) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= (state_d == ST_DONE);
        end
    end

    muldiv_datapath u_datapath (
        .clk_i           (MDU_clk_in),
        .rst_i           (MDU_reset_in),
        .capture_i       (capture_s),
        .load_i          (load_n_s & ~abort_s),
        .step_i          (step_n_s & ~abort_s),
        .fix_i           (fix_n_s & ~abort_s),
        .op3_i           (MDU_op3_in),
        .a_i             (MDU_valA_in),
        .b_i             (MDU_valB_in),
        .y_i             (MDU_Y_in),
        .supported_o     (supported_s),
        .is_mul_o        (is_mul_s),
        .prep_exit_o     (prep_exit_s),
        .cnt_last_o      (cnt_last_s),
        .mul_pre_exit_o  (mul_pre_exit_s),
        .mul_post_exit_o (mul_post_exit_s),
        .res_o           (MDU_res_out),
        .y_o             (MDU_Y_out),
        .y_we_o          (MDU_Y_we_out),
        .divzero_o       (MDU_divzero_out)
    );

    assign MDU_req_ready_out  = req_ready_s;
    assign MDU_resp_valid_out = resp_valid_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised bench for muldiv_sequencer with an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk, rst, req_valid, req_ready, flush, resp_valid, resp_ready;
    logic        y_we, divzero;
    logic [5:0]  op3;
    logic [31:0] val_a, val_b, y_in, res, y_out;

    muldiv_sequencer #(.MDU_XLEN(32)) dut (
        .MDU_clk_in(clk), .MDU_reset_in(rst),
        .MDU_req_valid_in(req_valid), .MDU_req_ready_out(req_ready),
        .MDU_op3_in(op3), .MDU_valA_in(val_a), .MDU_valB_in(val_b), .MDU_Y_in(y_in),
        .MDU_flush_in(flush),
        .MDU_resp_valid_out(resp_valid), .MDU_resp_ready_in(resp_ready),
        .MDU_res_out(res), .MDU_Y_out(y_out), .MDU_Y_we_out(y_we),
        .MDU_divzero_out(divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] yv;
        logic        ywe;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: results straight from the operation's arithmetic meaning.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] y);
        exp_t e;
        logic [63:0] p, md, mq;
        logic [31:0] mb;
        longint sp;
        int bl;
        e.res = 32'd0; e.yv = 32'd0; e.ywe = 1'b0; e.dz = 1'b0; e.lat = 2; e.acc = 0;
        case (op)
            6'h0A, 6'h0B: begin
                if (op == 6'h0B) begin
                    sp = longint'($signed(a)) * longint'($signed(b));
                    p  = sp;
                    mb = b[31] ? (32'd0 - b) : b;
                end else begin
                    p  = {32'd0, a} * {32'd0, b};
                    mb = b;
                end
                e.res = p[31:0]; e.yv = p[63:32]; e.ywe = 1'b1;
`ifdef MDU_EARLY_OUT_EN
                bl = 0;
                for (int i = 0; i < 32; i++) if (mb[i]) bl = i + 1;
                e.lat = 3 + bl;
`else
                bl = 0;
                e.lat = 34 + bl;
`endif
            end
            6'h0E: begin
                if (b == 32'd0) begin
                    e.res = 32'hFFFF_FFFF; e.dz = 1'b1;
                end else begin
                    mq = {y, a} / {32'd0, b};
                    if (mq > 64'h0000_0000_FFFF_FFFF) e.res = 32'hFFFF_FFFF;
                    else begin e.res = mq[31:0]; e.lat = 34; end
                end
            end
            6'h0F: begin
                if (b == 32'd0) begin
                    e.res = 32'hFFFF_FFFF; e.dz = 1'b1;
                end else begin
                    md = y[31] ? (64'd0 - {y, a}) : {y, a};
                    mb = b[31] ? (32'd0 - b) : b;
                    mq = md / {32'd0, mb};
                    if (mq <= 64'h0000_0000_FFFF_FFFF) e.lat = 34;
                    if (y[31] ^ b[31]) e.res = (mq > 64'h8000_0000) ? 32'h8000_0000 : (32'd0 - mq[31:0]);
                    else               e.res = (mq > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : mq[31:0];
                end
            end
            default: e.res = 32'd0;
        endcase
        return e;
    endfunction

    // Monitor/compare: handshakes sampled just before each rising edge,
    // outputs checked just after it.
    initial begin
        logic s_rst, s_acc, s_hs, s_fl;
        logic [5:0] s_op;
        logic [31:0] s_a, s_b, s_y;
        exp_t e;
        forever begin
            @(negedge clk); #4;
            s_rst = rst; s_acc = req_valid & req_ready; s_hs = resp_valid & resp_ready;
            s_fl = flush; s_op = op3; s_a = val_a; s_b = val_b; s_y = y_in;
            @(posedge clk);
            cyc++;
            if (s_rst) begin
                exp_q.delete(); seen = 1'b0;
            end else begin
                if ((s_hs || s_fl) && exp_q.size() > 0) begin
                    void'(exp_q.pop_front()); seen = 1'b0;
                end
                if (s_acc) begin
                    e = model(s_op, s_a, s_b, s_y); e.acc = cyc; exp_q.push_back(e);
                end
                #2;
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    if (resp_valid) begin
                        if (!seen) begin check("latency", 64'(cyc - e.acc), 64'(e.lat)); seen = 1'b1; end
                        check("res", res, e.res);
                        check("y_we", y_we, e.ywe);
                        check("divzero", divzero, e.dz);
                        if (e.ywe) check("y_out", y_out, e.yv);
                    end else if (cyc - e.acc > 80) begin
                        check("resp_timeout", 64'(cyc - e.acc), 64'(e.lat));
                        void'(exp_q.pop_front());
                    end
                    check("busy_ready", req_ready, 1'b0);
                end else begin
                    check("idle_valid", resp_valid, 1'b0);
                    if (!flush) check("idle_ready", req_ready, 1'b1);
                end
            end
        end
    end

    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] y);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; op3 = op; val_a = a; val_b = b; y_in = y;
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            if (req_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int hold);
        int n;
        bit done;
        n = 0; done = 1'b0;
        for (int i = 0; i < 150 && !done; i++) begin
            if (exp_q.size() == 0) done = 1'b1;
            else begin
                if (resp_valid) begin
                    if (n >= hold) resp_ready = 1'b1;
                    n++;
                end
                @(negedge clk);
            end
        end
        resp_ready = 1'b0;
        if (!done) check("resp_wait_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    localparam int ND = 14;
    logic [5:0]  d_op [ND] = '{6'h0A, 6'h0B, 6'h0E, 6'h0F, 6'h0E, 6'h0E, 6'h0F,
                               6'h0A, 6'h0A, 6'h0F, 6'h0F, 6'h3C, 6'h0B, 6'h0F};
    logic [31:0] d_a  [ND] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd100, 32'hFFFF_FF9C, 32'd0,
                               32'd1234, 32'd5, 32'd9, 32'h1234_5678, 32'h8000_0000,
                               32'h8000_0000, 32'd77, 32'h8000_0000, 32'd100};
    logic [31:0] d_b  [ND] = '{32'd2, 32'd7, 32'd7, 32'd7, 32'd3, 32'd0, 32'd0, 32'd1, 32'd0,
                               32'd1, 32'd1, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    logic [31:0] d_y  [ND] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd0,
                               32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};

    initial begin
        exp_t m;
        logic [5:0]  op;
        logic [31:0] a, b, y;
        int k;
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
        op3 = 6'd0; val_a = 32'd0; val_b = 32'd0; y_in = 32'd0;

        // Model pinned against hand-computed values.
        m = model(6'h0A, 32'hFFFF_FFFF, 32'd2, 32'd0);
        check("pin_umul_res", m.res, 32'hFFFF_FFFE); check("pin_umul_y", m.yv, 32'd1);
        m = model(6'h0B, 32'hFFFF_FFFD, 32'd7, 32'd0);
        check("pin_smul_res", m.res, 32'hFFFF_FFEB); check("pin_smul_y", m.yv, 32'hFFFF_FFFF);
        m = model(6'h0E, 32'd100, 32'd7, 32'd0);
        check("pin_udiv_res", m.res, 32'd14);
        m = model(6'h0F, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFF);
        check("pin_sdiv_res", m.res, 32'hFFFF_FFF2);
        m = model(6'h0E, 32'd0, 32'd3, 32'd5);
        check("pin_ovf_res", m.res, 32'hFFFF_FFFF); check("pin_ovf_lat", 64'(m.lat), 64'd2);
        m = model(6'h0F, 32'd5, 32'd0, 32'd0);
        check("pin_dz", m.dz, 1'b1);
        m = model(6'h0A, 32'd9, 32'd1, 32'd0);
`ifdef MDU_EARLY_OUT_EN
        check("pin_early_lat", 64'(m.lat), 64'd4);
`else
        check("pin_full_lat", 64'(m.lat), 64'd34);
`endif

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_res", res, 32'd0);
        check("rst_y_out", y_out, 32'd0);
        check("rst_y_we", y_we, 1'b0);
        check("rst_divzero", divzero, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_req_ready", req_ready, 1'b1);

        // Directed vectors.
        for (int i = 0; i < ND; i++) begin
            send(d_op[i], d_a[i], d_b[i], d_y[i]);
            wait_resp(i % 3);
        end

        // Flush mid-multiply at E10, then a fresh request with a stalled consumer.
        send(6'h0A, 32'h0000_1234, 32'h0000_FFFF, 32'd0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_resp_valid", resp_valid, 1'b0);
        check("flush_req_ready", req_ready, 1'b1);
        check("flush_dropped", 64'(exp_q.size()), 64'd0);
        send(6'h0A, 32'd9, 32'd1, 32'd0);
        wait_resp(5);

        // Randomised traffic.
        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(0, 4);
            case (k)
                0: op = 6'h0A;
                1: op = 6'h0B;
                2: op = 6'h0E;
                3: op = 6'h0F;
                default: op = 6'h20 | 6'($urandom_range(0, 31));
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(0, 15);
                2: b = 32'd0 - $urandom_range(1, 15);
                default: b = (t % 4 == 0) ? 32'd0 : $urandom;
            endcase
            if (op == 6'h0E)
                y = ($urandom_range(0, 3) == 0 || b == 32'd0) ? $urandom : ($urandom % b);
            else if (op == 6'h0F)
                y = ($urandom_range(0, 3) == 0) ? $urandom : {32{a[31]}};
            else
                y = $urandom;
            send(op, a, b, y);
            wait_resp($urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
